// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default XLEN/DEPTH, address-width helper.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;

    // Address width for a DEPTH-entry array; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux, x0/not-ready zeroing, optional write bypass.
// Latency: 0 cycles, raddr_i to rdata_o is purely combinational.
// Backpressure: none; always answers.
//
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write data forwarded to the read).
// Ports:
//   mem_i    stored array contents (pre-edge values)
//   ready_i  array valid; reads return 0 while low
//   we_i / waddr_i / wdata_i  write ports of the current cycle (used for bypass)
//   raddr_i  read address, rdata_o read data
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NWRITE = 2,
    parameter int AW     = addr_width(DEPTH)
) (
    input  logic [DEPTH-1:0][XLEN-1:0]  mem_i,
    input  logic                        ready_i,
    input  logic [NWRITE-1:0]           we_i,
    input  logic [NWRITE-1:0][AW-1:0]   waddr_i,
    input  logic [NWRITE-1:0][XLEN-1:0] wdata_i,
    input  logic [AW-1:0]               raddr_i,
    output logic [XLEN-1:0]             rdata_o
);

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rdata_o = '0;
        if (ready_i && (raddr_i != '0)) begin
            rdata_o = mem_i[raddr_i];
            // Ascending scan: the highest-indexed matching port overrides the rest.
            for (int p = 0; p < NWRITE; p++) begin
                if (we_i[p] && (waddr_i[p] == raddr_i)) begin
                    rdata_o = wdata_i[p];
                end
            end
        end
    end
`else
    // Without bypass the write ports do not affect the read; forwarding is done
    // upstream in the writeback stage.
    logic unused_wr_ports;
    assign unused_wr_ports = ^{we_i, waddr_i, wdata_i};

    always_comb begin
        rdata_o = '0;
        if (ready_i && (raddr_i != '0)) begin
            rdata_o = mem_i[raddr_i];
        end
    end
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port rv32i integer register file with x0 hardwired to zero and a hardware clear sweep.
// Latency: writes visible 1 edge after presentation; reads combinational.
// Backpressure: ready low during the DEPTH-cycle clear sweep; writes and clr_req are dropped then.
//
// Optional feature macro: REGFILE_BYPASS_EN (handled inside regfile_read_port).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   clr_req           pulse: start a clear sweep (only honoured while ready)
//   ready             array valid, writes accepted
//   we/waddr/wdata    NWRITE write ports, highest index wins on address conflict
//   raddr/rdata       NREAD combinational read ports
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    parameter int AW     = addr_width(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr_req,
    output logic                        ready,
    input  logic [NWRITE-1:0]           we,
    input  logic [NWRITE-1:0][AW-1:0]   waddr,
    input  logic [NWRITE-1:0][XLEN-1:0] wdata,
    input  logic [NREAD-1:0][AW-1:0]    raddr,
    output logic [NREAD-1:0][XLEN-1:0]  rdata
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    rf_state_e                 state_q, state_d;
    logic [AW-1:0]             clr_idx_q, clr_idx_d;
    logic [DEPTH-1:0][XLEN-1:0] mem_q, mem_d;
    logic                      wr_allow;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                // The counter parks on the last index instead of wrapping.
                if (clr_idx_q == LAST_IDX) begin
                    state_d = READY;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            READY: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready    = (state_q == READY);
        // A write in the same cycle as clr_req would be wiped by the sweep anyway.
        wr_allow = (state_q == READY) && !clr_req;
    end

    // ---------------- array update ----------------
    always_comb begin
        mem_d = mem_q;
        if (state_q == CLEAR) begin
            mem_d[clr_idx_q] = '0;
        end else if (wr_allow) begin
            // Ascending order gives the highest-indexed port the last word.
            for (int p = 0; p < NWRITE; p++) begin
                if (we[p] && (waddr[p] != '0)) begin
                    mem_d[waddr[p]] = wdata[p];
                end
            end
        end
        mem_d[0] = '0;
    end

    // Storage has no reset of its own; the clear sweep initialises it, and
    // reads are forced to zero until the sweep completes.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            mem_q <= mem_d;
        end
    end

    // ---------------- read ports ----------------
    for (genvar r = 0; r < NREAD; r++) begin : g_rd
        regfile_read_port #(
            .XLEN   (XLEN),
            .DEPTH  (DEPTH),
            .NWRITE (NWRITE),
            .AW     (AW)
        ) u_rd (
            .mem_i   (mem_q),
            .ready_i (ready),
            .we_i    (we),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .raddr_i (raddr[r]),
            .rdata_o (rdata[r])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 32;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int AW     = 5;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        clr_req;
    logic                        ready;
    logic [NWRITE-1:0]           we;
    logic [NWRITE-1:0][AW-1:0]   waddr;
    logic [NWRITE-1:0][XLEN-1:0] wdata;
    logic [NREAD-1:0][AW-1:0]    raddr;
    logic [NREAD-1:0][XLEN-1:0]  rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register contents, validity flag, sweep cycles remaining.
    logic [XLEN-1:0] m_mem [DEPTH];
    bit              m_ready = 1'b0;
    int              m_left  = DEPTH;

    regfile_mp #(
        .XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NREAD), .NWRITE(NWRITE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .ready   (ready),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   (raddr),
        .rdata   (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        if (!m_ready || a == '0) return '0;
        v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NWRITE; p++)
            if (we[p] && waddr[p] == a) v = wdata[p];
`endif
        return v;
    endfunction

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    // Advance the model by one edge from the currently driven inputs.
    task automatic model_edge();
        if (!rst_n) begin
            m_ready = 1'b0; m_left = DEPTH; zero_model();
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) m_ready = 1'b1;
        end else if (clr_req) begin
            m_ready = 1'b0; m_left = DEPTH; zero_model();
        end else begin
            for (int p = 0; p < NWRITE; p++)
                if (we[p] && waddr[p] != '0) m_mem[waddr[p]] = wdata[p];
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ready"}, XLEN'(ready), XLEN'(m_ready));
        for (int r = 0; r < NREAD; r++)
            check({tag, ".rdata"}, rdata[r], exp_rd(raddr[r]));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        clr_req = 1'b0; we = '0; waddr = '0; wdata = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        raddr = '0;
        zero_model();

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            raddr[0] = AW'(i + 1); raddr[1] = AW'(i + 4);
            tick("reset");
            check("reset.ready0", XLEN'(ready), '0);
        end
        rst_n = 1'b1;

        // Sweep: ready low after edges 1..31, high after edge 32.
        for (int i = 1; i <= DEPTH; i++) begin
            tick("sweep");
            check("sweep.ready_edge", XLEN'(ready), (i == DEPTH) ? 32'd1 : 32'd0);
        end

        // Every register reads zero after the sweep.
        for (int a = 0; a < DEPTH; a++) begin
            raddr[0] = AW'(a); raddr[1] = AW'(DEPTH - 1 - a);
            #1;
            check("post_sweep.r0", rdata[0], '0);
            check("post_sweep.r1", rdata[1], '0);
        end

        // Basic write/read.
        we = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'hDEADBEEF;
        tick("wr_x5");
        idle_inputs();
        raddr[1] = 5'd5; #1;
        check("basic.x5", rdata[1], 32'hDEADBEEF);

        // Write to x0 is discarded.
        we = 2'b10; waddr[1] = 5'd0; wdata[1] = 32'h12345678; raddr[0] = 5'd0;
        tick("wr_x0");
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick("x0_idle");
            check("x0.zero", rdata[0], '0);
        end

        // Two ports to one address: port 1 wins.
        we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
        wdata[0] = 32'h1111; wdata[1] = 32'h2222;
        tick("conflict");
        idle_inputs();
        raddr[0] = 5'd7; #1;
        check("conflict.x7", rdata[0], 32'h2222);

        // Same-cycle read of a register being written.
        raddr[0] = 5'd9; raddr[1] = 5'd9;
        we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'hCAFE; #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass.same_cycle", rdata[0], 32'hCAFE);
`else
        check("bypass.same_cycle", rdata[0], 32'h0);
`endif
        check_all("bypass");
        tick("bypass_edge");
        idle_inputs(); #1;
        check("bypass.after", rdata[1], 32'hCAFE);

        // Randomised traffic with occasional clears and resets.
        for (int i = 0; i < 400; i++) begin
            rst_n   = ($urandom_range(0, 149) != 0);
            clr_req = ($urandom_range(0, 39) == 0);
            for (int p = 0; p < NWRITE; p++) begin
                we[p]    = $urandom_range(0, 2) != 0;
                waddr[p] = AW'($urandom_range(0, 11));
                wdata[p] = $urandom;
            end
            for (int r = 0; r < NREAD; r++) raddr[r] = AW'($urandom_range(0, 11));
            #1;
            check_all("rand_pre");
            tick("rand");
        end
        rst_n = 1'b1;
        idle_inputs();
        while (!m_ready) tick("drain");

        // Clear request and reset interplay.
        we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'hAA;
        tick("wr_x3");
        raddr[0] = 5'd3; #1;
        check("clr.x3_before", rdata[0], 32'hAA);
        clr_req = 1'b1; we = 2'b10; waddr[1] = 5'd4; wdata[1] = 32'h55;
        tick("clr_req");
        check("clr.ready_drop", XLEN'(ready), '0);
        clr_req = 1'b0;
        for (int i = 0; i < 9; i++) begin
            we = 2'b11; waddr[0] = 5'd3; waddr[1] = 5'd4;
            wdata[0] = $urandom; wdata[1] = $urandom;
            clr_req = (i == 4);
            tick("clr_sweep");
        end
        rst_n = 1'b0;
        tick("clr_rst");
        rst_n = 1'b1; clr_req = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'hFFFF_0000 | i;
            tick("clr_resweep");
            check("clr.resweep_ready", XLEN'(ready), (i == DEPTH) ? 32'd1 : 32'd0);
        end
        idle_inputs();
        raddr[0] = 5'd3; raddr[1] = 5'd4; #1;
        check("clr.x3_after", rdata[0], '0);
        check("clr.x4_after", rdata[1], '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the rv32i core: NREAD asynchronous read ports, NWRITE synchronous write ports, register 0 hardwired to zero, and a hardware clear sequencer that zeroes the array after reset or on request. It replaces the single-write/dual-read register file in the decode/writeback path. It also supports multi-issue and extra read-port variants.

## Interface
- XLEN, 32: register width in bits.
- DEPTH, 32: number of registers; power of two, at least 2; AW = $clog2(DEPTH).
- NREAD, 2: number of read ports, at least 1.
- NWRITE, 2: number of write ports, at least 1.

- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- clr_req  in  1  single-cycle pulse; starts a clear sweep when in READY.
- ready  out  1  high when the array is valid and writes are accepted.
- we  in  NWRITE  per-port write enable.
- waddr  in  NWRITE x AW  per-port write address.
- wdata  in  NWRITE x XLEN  per-port write data.
- raddr  in  NREAD x AW  per-port read address.
- rdata  out  NREAD x XLEN  per-port read data; combinational.

## Operation
- Two-state FSM: CLEAR and READY.
- Reset:
  - rst_n low at a clock edge sets state to CLEAR, clr_idx to 0 and ready to 0.
  - Reset mid-sweep restarts the sweep at index 0.
- CLEAR:
  - Each cycle writes 0 to mem[clr_idx], then clr_idx increments.
  - On the cycle clr_idx == DEPTH-1 the counter does not wrap; state goes to READY and ready goes to 1.
  - we is ignored and clr_req is ignored.
- READY:
  - clr_req=1 moves to CLEAR with clr_idx=0 and ready=0.
  - Writes presented in the same cycle as clr_req are dropped.
- Writes (READY only):
  - Port p with we[p]=1 and waddr[p]!=0 updates mem[waddr[p]] at the clock edge.
  - Writes to address 0 are discarded.
  - Multiple enabled ports targeting the same address: the highest-indexed port wins.
- Reads:
  - rdata[r] = 0 when raddr[r]==0 or ready==0.
  - Otherwise rdata[r] = mem[raddr[r]], subject to the bypass behaviour in Configuration.
  - mem[0] is never written and always reads 0.

## Timing
- Clear sweep takes exactly DEPTH cycles from the first clock edge with rst_n high; ready rises on the following edge.
- Reset value of every output:
  - ready = 0.
  - rdata = 0 for all ports.
- Write latency is 1 edge: data written at edge N is readable from mem immediately after edge N.
- Read path is fully combinational: no registers between raddr and rdata.
- clr_req arriving while already in CLEAR has no effect; the sweep is not extended.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Applies when ready=1 and raddr[r]!=0.
  - If any enabled write port targets raddr[r] in the same cycle, rdata[r] returns that port's wdata; the highest-indexed matching port wins.
  - Gives write-before-read semantics within a cycle.
- REGFILE_BYPASS_EN undefined:
  - rdata[r] returns the pre-edge stored value.
  - The writeback stage must forward externally.

## Structure
- Shared package regfile_pkg holds:
  - the state enum (CLEAR, READY);
  - default XLEN/DEPTH constants;
  - the address width function.
- One sub-module, regfile_read_port: a single read mux plus zero/bypass logic.
  - Instantiated NREAD times in a generate loop.
  - Takes the mem array, the write ports and ready as inputs.
- Write-priority resolution and the clear sequencer stay in the top module.

## Test plan
- Reset then sweep:
  - Hold rst_n=0 for 3 cycles, then release.
  - Required: ready=0 for exactly 32 edges, then 1; all 32 registers read 0.
- Basic write/read:
  - Port 0 writes 0xDEADBEEF to x5.
  - Required: next cycle, raddr[1]=5 returns 0xDEADBEEF.
- Write to x0:
  - Port 1 writes 0x12345678 to x0.
  - Required: x0 reads 0 on every subsequent cycle.
- Write conflict:
  - Port 0 writes 0x1111 and port 1 writes 0x2222 to x7 in the same cycle.
  - Required: x7 reads 0x2222.
- Bypass:
  - Write 0xCAFE to x9 while raddr[0]=9 in the same cycle.
  - Required: with REGFILE_BYPASS_EN, rdata[0]=0xCAFE that cycle; without it, the old value.
- Clear and reset interplay:
  - Assert clr_req with x3=0xAA.
  - Required: ready drops on the next edge and writes are ignored during the sweep; rst_n pulsed at sweep cycle 10 restarts a full 32-cycle sweep; x3 reads 0 afterwards.
